// File: rtl/rx_pause_detect.sv
// Receive-side 802.3x PAUSE detector: parses MAC Control frames on the RX byte
// stream and runs the quanta timer that holds the local transmitter off.
`timescale 1ns/1ps

module rx_pause_detect #(
    parameter logic [47:0] PAUSE_DA      = 48'h0180C2000001,
    parameter logic [47:0] STATION_ADDR  = 48'h000000000000,
    parameter int          QUANTA_CYCLES = 64
) (
    input  logic        rx_clk,
    input  logic        rx_rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_last,
    input  logic        rx_error,
    output logic        pause_active,
    output logic [15:0] pause_quanta,
    output logic [47:0] pause_source_addr,
    output logic        pause_frame_stb,
    output logic [15:0] pause_quanta_left
);

    localparam int                PRE_W      = $clog2(QUANTA_CYCLES);
    localparam logic [PRE_W-1:0]  PRE_RELOAD = PRE_W'(QUANTA_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HDR, WAIT_END, DROP} state_t;

    state_t       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         daPause_q, daPause_d;
    logic         daStation_q, daStation_d;
    logic         errFlag_q, errFlag_d;
    logic         resync_q, resync_d;
    logic         firstCycle_q;
    logic [47:0]  saShadow_q, saShadow_d;
    logic [15:0]  quantaShadow_q, quantaShadow_d;
    logic         commit;

    logic         stb_q;
    logic [15:0]  quanta_q;
    logic [47:0]  srcAddr_q;
    logic [15:0]  quantaCnt_q;
    logic [PRE_W-1:0] presc_q;

    logic [4:0]   idx;
    logic         daPauseHit, daStationHit, fieldOk, byteOk;

    function automatic logic [7:0] addrByte(input logic [47:0] a, input logic [4:0] i);
        case (i)
            5'd0:    return a[47:40];
            5'd1:    return a[39:32];
            5'd2:    return a[31:24];
            5'd3:    return a[23:16];
            5'd4:    return a[15:8];
            5'd5:    return a[7:0];
            default: return 8'h00;
        endcase
    endfunction

    // The byte arriving in IDLE is always byte 0 of a new frame.
    always_comb begin
        idx          = (state_q == IDLE) ? 5'd0 : cnt_q;
        daPauseHit   = ((idx == 5'd0) || daPause_q) &&
                       ((idx > 5'd5) || (rx_data == addrByte(PAUSE_DA, idx)));
        daStationHit = ((idx == 5'd0) || daStation_q) &&
                       ((idx > 5'd5) || (rx_data == addrByte(STATION_ADDR, idx)));
        case (idx)
            5'd12:   fieldOk = (rx_data == 8'h88);
            5'd13:   fieldOk = (rx_data == 8'h08);
            5'd14:   fieldOk = (rx_data == 8'h00);
            5'd15:   fieldOk = (rx_data == 8'h01);
            default: fieldOk = 1'b1;
        endcase
        byteOk = (daPauseHit || daStationHit) && fieldOk && !rx_error;
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        daPause_d      = daPause_q;
        daStation_d    = daStation_q;
        errFlag_d      = errFlag_q;
        resync_d       = resync_q;
        saShadow_d     = saShadow_q;
        quantaShadow_d = quantaShadow_q;
        commit         = 1'b0;

        // Valid data on the very first cycle after reset means a frame was cut in half.
        if (resync_q) begin
            if ((firstCycle_q && !rx_valid) || (rx_valid && rx_last)) begin
                resync_d = 1'b0;
            end
        end else if (rx_valid) begin
            case (state_q)
                IDLE, HDR: begin
                    daPause_d   = daPauseHit;
                    daStation_d = daStationHit;
                    if (idx >= 5'd6 && idx <= 5'd11) begin
                        saShadow_d = {saShadow_q[39:0], rx_data};
                    end
                    if (idx >= 5'd16 && idx <= 5'd17) begin
                        quantaShadow_d = {quantaShadow_q[7:0], rx_data};
                    end
                    cnt_d = idx + 5'd1;
                    if (rx_last) begin
                        commit  = (idx == 5'd17) && byteOk;
                        state_d = IDLE;
                        cnt_d   = 5'd0;
                    end else if (!byteOk) begin
                        state_d = DROP;
                    end else if (idx == 5'd17) begin
                        state_d = WAIT_END;
                    end else begin
                        state_d = HDR;
                    end
                end
                WAIT_END: begin
                    if (cnt_q != 5'd18) cnt_d = cnt_q + 5'd1;
                    errFlag_d = errFlag_q | rx_error;
                    if (rx_last) begin
                        commit    = !(errFlag_q | rx_error);
                        state_d   = IDLE;
                        cnt_d     = 5'd0;
                        errFlag_d = 1'b0;
                    end
                end
                DROP: begin
                    if (cnt_q != 5'd18) cnt_d = cnt_q + 5'd1;
                    if (rx_last) begin
                        state_d = IDLE;
                        cnt_d   = 5'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= 5'd0;
            daPause_q      <= 1'b0;
            daStation_q    <= 1'b0;
            errFlag_q      <= 1'b0;
            resync_q       <= 1'b1;
            firstCycle_q   <= 1'b1;
            saShadow_q     <= 48'h0;
            quantaShadow_q <= 16'h0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            daPause_q      <= daPause_d;
            daStation_q    <= daStation_d;
            errFlag_q      <= errFlag_d;
            resync_q       <= resync_d;
            firstCycle_q   <= 1'b0;
            saShadow_q     <= saShadow_d;
            quantaShadow_q <= quantaShadow_d;
        end
    end

    // A new commit overrides any remaining pause time rather than adding to it.
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            stb_q       <= 1'b0;
            quanta_q    <= 16'h0;
            srcAddr_q   <= 48'h0;
            quantaCnt_q <= 16'h0;
            presc_q     <= '0;
        end else begin
            stb_q <= commit;
            if (commit) begin
                quanta_q    <= quantaShadow_d;
                srcAddr_q   <= saShadow_d;
                quantaCnt_q <= quantaShadow_d;
                presc_q     <= PRE_RELOAD;
            end else if (quantaCnt_q != 16'h0) begin
                if (presc_q == '0) begin
                    presc_q     <= PRE_RELOAD;
                    quantaCnt_q <= quantaCnt_q - 16'h1;
                end else begin
                    presc_q <= presc_q - 1'b1;
                end
            end
        end
    end

    assign pause_active      = (quantaCnt_q != 16'h0);
    assign pause_quanta      = quanta_q;
    assign pause_source_addr = srcAddr_q;
    assign pause_frame_stb   = stb_q;
    assign pause_quanta_left = quantaCnt_q;

endmodule

// File: tb/tb_rx_pause_detect.sv
// Self-checking bench for rx_pause_detect: frame-level acceptance model plus a
// remaining-time pause model compared against the DUT every cycle.
`timescale 1ns/1ps

module tb_rx_pause_detect;

    localparam logic [47:0] PAUSE_DA     = 48'h0180C2000001;
    localparam logic [47:0] STATION_ADDR = 48'h000000000000;
    localparam int          QC           = 64;

    logic        rx_clk = 1'b0;
    logic        rx_rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_last = 1'b0;
    logic        rx_error = 1'b0;
    logic        pause_active;
    logic [15:0] pause_quanta;
    logic [47:0] pause_source_addr;
    logic        pause_frame_stb;
    logic [15:0] pause_quanta_left;

    rx_pause_detect #(
        .PAUSE_DA      (PAUSE_DA),
        .STATION_ADDR  (STATION_ADDR),
        .QUANTA_CYCLES (QC)
    ) dut (
        .rx_clk            (rx_clk),
        .rx_rst_n          (rx_rst_n),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_last           (rx_last),
        .rx_error          (rx_error),
        .pause_active      (pause_active),
        .pause_quanta      (pause_quanta),
        .pause_source_addr (pause_source_addr),
        .pause_frame_stb   (pause_frame_stb),
        .pause_quanta_left (pause_quanta_left)
    );

    always #5 rx_clk = ~rx_clk;

    int checks = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Driver publishes accepted frames by bumping pendSeq; the model commits on the next edge.
    int          pendSeq = 0;
    logic [15:0] pendQ = 16'h0;
    logic [47:0] pendSa = 48'h0;
    int          seenSeq = 0;
    int          remaining = 0;
    logic        expStb = 1'b0;
    logic [15:0] expQuanta = 16'h0;
    logic [47:0] expSa = 48'h0;
    bit          checkEn = 1'b0;
    int          activeTotal = 0;

    always @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            remaining = 0;
            expStb    = 1'b0;
            expQuanta = 16'h0;
            expSa     = 48'h0;
            seenSeq   = pendSeq;
        end else begin
            expStb = 1'b0;
            if (remaining > 0) remaining--;
            if (pendSeq != seenSeq) begin
                seenSeq   = pendSeq;
                remaining = int'(pendQ) * QC;
                expStb    = 1'b1;
                expQuanta = pendQ;
                expSa     = pendSa;
            end
        end
    end

    always @(negedge rx_clk) begin
        if (checkEn) begin
            checkOutput("pause_active", pause_active, remaining > 0);
            checkOutput("quanta_left", pause_quanta_left, (remaining + QC - 1) / QC);
            checkOutput("frame_stb", pause_frame_stb, expStb);
            checkOutput("pause_quanta", pause_quanta, expQuanta);
            checkOutput("source_addr", pause_source_addr, expSa);
            if (pause_active) activeTotal++;
        end
    end

    logic [7:0] txFrame[$];

    function automatic bit frameAccepted(input int errIdx);
        logic [47:0] da;
        if (txFrame.size() < 18) return 1'b0;
        if (errIdx >= 0 && errIdx < txFrame.size()) return 1'b0;
        da = {txFrame[0], txFrame[1], txFrame[2], txFrame[3], txFrame[4], txFrame[5]};
        if (da != PAUSE_DA && da != STATION_ADDR) return 1'b0;
        return txFrame[12] == 8'h88 && txFrame[13] == 8'h08 &&
               txFrame[14] == 8'h00 && txFrame[15] == 8'h01;
    endfunction

    task automatic buildPause(input logic [47:0] da, input logic [47:0] sa,
                              input logic [15:0] q, input int len);
        txFrame.delete();
        for (int i = 0; i < 6; i++) txFrame.push_back(da[8*(5-i) +: 8]);
        for (int i = 0; i < 6; i++) txFrame.push_back(sa[8*(5-i) +: 8]);
        txFrame.push_back(8'h88);
        txFrame.push_back(8'h08);
        txFrame.push_back(8'h00);
        txFrame.push_back(8'h01);
        txFrame.push_back(q[15:8]);
        txFrame.push_back(q[7:0]);
        while (txFrame.size() < len) txFrame.push_back(8'($urandom_range(0, 255)));
        while (txFrame.size() > len) void'(txFrame.pop_back());
    endtask

    task automatic idleCycles(input int n);
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_error = 1'b0;
        repeat (n) @(posedge rx_clk);
        #1;
    endtask

    task automatic applyStimulus(input int errIdx, input int minGap, input int maxGap);
        bit acc;
        acc = frameAccepted(errIdx);
        for (int i = 0; i < txFrame.size(); i++) begin
            if (i > 0 && maxGap > 0) begin
                int g;
                g = $urandom_range(minGap, maxGap);
                if (g > 0) idleCycles(g);
            end
            rx_data  = txFrame[i];
            rx_valid = 1'b1;
            rx_last  = (i == txFrame.size() - 1);
            rx_error = (i == errIdx);
            if (rx_last && acc) begin
                pendQ  = {txFrame[16], txFrame[17]};
                pendSa = {txFrame[6], txFrame[7], txFrame[8], txFrame[9], txFrame[10], txFrame[11]};
                pendSeq++;
            end
            @(posedge rx_clk);
            #1;
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_active"}, pause_active, 1'b0);
        checkOutput({tag, "_stb"}, pause_frame_stb, 1'b0);
        checkOutput({tag, "_quanta"}, pause_quanta, 16'h0);
        checkOutput({tag, "_sa"}, pause_source_addr, 48'h0);
        checkOutput({tag, "_left"}, pause_quanta_left, 16'h0);
    endtask

    localparam logic [47:0] SA1 = 48'h001122334455;

    initial begin
        int base;

        repeat (3) @(posedge rx_clk);
        #1;
        checkAllZero("reset");
        rx_rst_n = 1'b1;
        checkEn  = 1'b1;
        idleCycles(3);

        $display("[TB] basic PAUSE frame");
        base = activeTotal;
        buildPause(PAUSE_DA, SA1, 16'h0003, 60);
        applyStimulus(-1, 0, 0);
        checkOutput("t1_stb_after_last", pause_frame_stb, 1'b1);
        checkOutput("t1_sa", pause_source_addr, SA1);
        checkOutput("t1_left_start", pause_quanta_left, 16'd3);
        idleCycles(250);
        checkOutput("t1_active_cycles", activeTotal - base, 192);

        $display("[TB] PAUSE frame with valid gaps");
        base = activeTotal;
        buildPause(PAUSE_DA, SA1, 16'h0003, 60);
        applyStimulus(-1, 1, 3);
        checkOutput("t2_stb_after_last", pause_frame_stb, 1'b1);
        idleCycles(250);
        checkOutput("t2_active_cycles", activeTotal - base, 192);

        $display("[TB] rejected frames");
        base = activeTotal;
        buildPause(PAUSE_DA, SA1, 16'h0004, 60);
        txFrame[12] = 8'h08;
        txFrame[13] = 8'h00;
        applyStimulus(-1, 0, 0);
        idleCycles(5);
        buildPause(PAUSE_DA, SA1, 16'h0004, 60);
        txFrame[14] = 8'h01;
        applyStimulus(-1, 0, 0);
        idleCycles(5);
        buildPause(48'h0180C2000002, SA1, 16'h0004, 60);
        applyStimulus(-1, 0, 0);
        idleCycles(5);
        buildPause(PAUSE_DA, SA1, 16'h0004, 60);
        applyStimulus(40, 0, 0);
        idleCycles(5);
        buildPause(PAUSE_DA, SA1, 16'h0004, 15);
        applyStimulus(-1, 0, 0);
        idleCycles(20);
        checkOutput("t3_no_pause", activeTotal - base, 0);

        $display("[TB] zero quanta cancels pause");
        buildPause(PAUSE_DA, SA1, 16'h0010, 60);
        applyStimulus(-1, 0, 0);
        idleCycles(100);
        buildPause(PAUSE_DA, 48'hA0A1A2A3A4A5, 16'h0000, 60);
        applyStimulus(-1, 0, 0);
        checkOutput("t4_active_dropped", pause_active, 1'b0);
        checkOutput("t4_quanta_zero", pause_quanta, 16'h0);
        idleCycles(10);

        $display("[TB] override without accumulation");
        buildPause(PAUSE_DA, SA1, 16'h0002, 60);
        applyStimulus(-1, 0, 0);
        idleCycles(50);
        buildPause(PAUSE_DA, SA1, 16'h0001, 60);
        applyStimulus(-1, 0, 0);
        base = activeTotal;
        idleCycles(150);
        checkOutput("t5_active_cycles", activeTotal - base, 64);

        $display("[TB] reset mid-pause and mid-frame");
        buildPause(PAUSE_DA, SA1, 16'h0005, 60);
        applyStimulus(-1, 0, 0);
        idleCycles(20);
        for (int i = 0; i < 25; i++) begin
            rx_data  = 8'($urandom_range(0, 255));
            rx_valid = 1'b1;
            rx_last  = 1'b0;
            if (i == 10) begin
                rx_rst_n = 1'b0;
                #1;
                checkAllZero("t6_async");
                base = activeTotal;
            end
            @(posedge rx_clk);
            #1;
        end
        buildPause(PAUSE_DA, SA1, 16'h0002, 40);
        for (int i = 0; i < txFrame.size(); i++) begin
            if (i == 0) rx_rst_n = 1'b1;
            rx_data  = txFrame[i];
            rx_valid = 1'b1;
            rx_last  = (i == txFrame.size() - 1);
            @(posedge rx_clk);
            #1;
        end
        idleCycles(20);
        checkOutput("t6_tail_ignored", activeTotal - base, 0);
        base = activeTotal;
        buildPause(PAUSE_DA, 48'h0A0B0C0D0E0F, 16'h0001, 60);
        applyStimulus(-1, 0, 0);
        checkOutput("t6_accept_after_reset", pause_frame_stb, 1'b1);
        idleCycles(80);
        checkOutput("t6_active_cycles", activeTotal - base, 64);

        $display("[TB] randomized frames");
        for (int n = 0; n < 30; n++) begin
            int kind, len, errIdx;
            logic [47:0] sa, da;
            logic [15:0] q;
            kind   = $urandom_range(0, 5);
            sa     = {16'($urandom()), 32'($urandom())};
            da     = ($urandom_range(0, 1) == 0) ? PAUSE_DA : STATION_ADDR;
            q      = 16'($urandom_range(0, 4));
            len    = (kind == 5) ? $urandom_range(1, 17) : $urandom_range(18, 70);
            errIdx = -1;
            buildPause(da, sa, q, len);
            if (kind == 3) begin
                int pos;
                pos = $urandom_range(0, 15);
                txFrame[pos] = txFrame[pos] ^ 8'($urandom_range(1, 255));
            end
            if (kind == 4) errIdx = $urandom_range(0, len - 1);
            applyStimulus(errIdx, 0, 2);
            idleCycles($urandom_range(0, 120));
        end

        idleCycles(300);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
